eth_cfg_loader: RTL and testbench
=================================

Name: eth_cfg_loader

Overview:
- Drives the Ethernet configuration shift interface (cfg_valid / cfg_mem_sel / cfg_wdata / cfg_enable_rx) of the GTX Ethernet bridge from the cfg_clk side.
- Streams the 10-byte MAC/IP memory and the 16-byte UDP-port memory in an order that realigns the receiver's address pointer regardless of its prior state.
- Gates cfg_enable_rx until a complete load has landed.
- Sits between the board-level register/boot logic and the bridge.

Parameters:
- GAP, 0: idle cycles inserted between consecutive cfg_valid strobes (0..15).
- AUTO_START, 1: start a load automatically on the first cycle after reset deassertion.

Ports:
- cfg_clk  in  1  configuration clock; all logic on rising edge.
- cfg_rst_n  in  1  reset, asynchronous assert, active-low; deassertion synchronous to cfg_clk externally.
- start  in  1  single-cycle load request; ignored while busy.
- mac  in  48  MAC address, mac[47:40] transmitted first; sampled on accepted start.
- ip  in  32  IPv4 address, ip[31:24] first; sampled on accepted start.
- udp_ports  in  128  eight 16-bit ports, port k = udp_ports[16k+15:16k]; sampled on accepted start.
- cfg_valid  out  1  write strobe to bridge.
- cfg_mem_sel  out  1  0 = MAC/IP memory, 1 = UDP memory.
- cfg_wdata  out  8  write byte.
- cfg_enable_rx  out  1  RX enable to bridge.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse at load completion.
- load_count  out  8  completed loads, wraps 255->0.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; shadow registers cleared.
- Reset mid-load: everything returns to reset values immediately. The next load's preamble realigns the bridge.
- States and transitions:
  - IDLE: accepted start (or AUTO_START on the first post-reset cycle) latches mac/ip/udp_ports into shadow registers, clears cfg_enable_rx and goes to PRE.
  - PRE: one strobe, cfg_mem_sel=1, wdata = port0[15:8]. Then MACIP.
  - MACIP: 10 strobes, cfg_mem_sel=0. Bytes are mac[47:40] .. mac[7:0], then ip[31:24] .. ip[7:0]. Then UDP.
  - UDP: 16 strobes, cfg_mem_sel=1. Byte 2k = port k [15:8]; byte 2k+1 = port k [7:0]. Then FIN.
  - FIN: done=1, cfg_enable_rx=1, load_count+1, then IDLE.
- Rationale for the ordering:
  - The PRE strobe forces the bridge's previous-select to UDP.
  - The MACIP entry is therefore always a select switch, so its first byte lands at address 0.
  - The UDP entry is likewise always a switch, so its first byte lands at address 0.
  - Any stray byte written by PRE is overwritten by the full UDP pass.
- Timing, GAP=0: start accepted at cycle t; cfg_valid high for cycles t+1..t+27 (27 strobes); done and cfg_enable_rx rise at t+28; busy high t+1..t+28.
- Timing, GAP=G: strobes spaced G+1 cycles; first strobe t+1, last strobe t+1+26(G+1); FIN is the next cycle after the last strobe.
- Between strobes: cfg_valid=0; cfg_mem_sel and cfg_wdata hold their last values.
- Outputs are registered; cfg_mem_sel and cfg_wdata are valid in the same cycle as cfg_valid.
- Byte index: 4-bit counter, cleared on every state entry. A phase ends when index == size-1 and a strobe fires.
- cfg_enable_rx: stays 1 after FIN until the next accepted start. It is 0 from reset until the first FIN.
- start while busy: ignored, not queued. start in the same cycle as FIN: ignored.
- Shadow registers are not affected by input changes during a load.

Decomposition:
- Shared package eth_cfg_pkg holds:
  - MACIP_MEM_SZ=10, UDP_MEM_SZ=16
  - SEL_MACIP=0, SEL_UDP=1
  - LOAD_STROBES=27
  - state encoding IDLE/PRE/MACIP/UDP/FIN
- One sub-module, eth_cfg_pacer:
  - 4-bit gap down-counter; emits a strobe-enable every GAP+1 cycles while enabled.
  - Restarts on enable rise, so the first strobe is immediate.

Test Plan:
- Reset release, AUTO_START=1, GAP=0, mac=48'h112233445566, ip=C0A80704, udp_ports=0 -> 27 contiguous strobes:
  - sel=1/00
  - sel=0: 11 22 33 44 55 66 C0 A8 07 04
  - sel=1: sixteen 00
  - then done pulse; cfg_enable_rx=1; load_count=1.
- Bench model of the bridge pointer with prev_sel randomly preset to 0 or 1 and ptr random -> after load, MAC/IP memory reads 112233445566C0A80704 and UDP memory equals udp_ports; checked in both preset cases.
- GAP=3, udp_ports port0=16'h0BB8 -> cfg_valid spacing exactly 4 cycles; last strobe at t+105; done at t+106; UDP bytes 0/1 = 0B/B8.
- start pulsed at strobe 5 of an active load, and again on the FIN cycle -> both ignored; exactly 27 strobes total; load_count increments by 1.
- cfg_rst_n asserted during the UDP phase, then start -> outputs 0 asynchronously; cfg_enable_rx stays 0; new load completes with memories correct under the bridge model.
- 256 back-to-back loads -> load_count wraps to 0; cfg_enable_rx drops to 0 the cycle after each accepted start.

Source files
------------

// File: rtl/eth_cfg_pkg.sv
// Shared constants, state encoding and byte-selection helpers for the
// Ethernet configuration loader.
package eth_cfg_pkg;

    localparam int MACIP_MEM_SZ = 10;
    localparam int UDP_MEM_SZ   = 16;
    localparam int LOAD_STROBES = 27;

    localparam logic SEL_MACIP = 1'b0;
    localparam logic SEL_UDP   = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_MACIP = 3'd2,
        ST_UDP   = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    // Byte idx of the packed {mac, ip} shadow, most significant byte first.
    function automatic logic [7:0] macip_byte(input logic [79:0] bytes, input logic [3:0] idx);
        return bytes[8*(MACIP_MEM_SZ-1-int'(idx)) +: 8];
    endfunction

    // Byte idx of the UDP port table: even index = high byte of port idx/2.
    function automatic logic [7:0] udp_byte(input logic [127:0] ports, input logic [3:0] idx);
        return ports[16*int'(idx[3:1]) + (idx[0] ? 0 : 8) +: 8];
    endfunction

endpackage

// File: rtl/eth_cfg_pacer.sv
// Strobe pacer: while enabled, fires once every GAP+1 cycles. The counter
// is held at zero while disabled, so the first fire after enable is immediate.
module eth_cfg_pacer #(
    parameter int GAP = 0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_fire
);

    localparam logic [3:0] GAP_L = 4'(GAP);

    logic [3:0] r_cnt;

    assign o_fire = i_en && (r_cnt == 4'd0);

    // Gap down-counter: reload after each fire, park at zero when idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= 4'd0;
        end else if (!i_en) begin
            r_cnt <= 4'd0;
        end else if (o_fire) begin
            r_cnt <= GAP_L;
        end else begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

endmodule

// File: rtl/eth_cfg_loader.sv
// Streams the MAC/IP and UDP-port memories into the GTX Ethernet bridge
// configuration port. A leading UDP-select strobe forces the bridge's
// select history so both real phases start on a select switch (address 0).
// Outputs are registered from the next-state view, so each strobe and its
// select/data appear in the same cycle the FSM reports that phase.
module eth_cfg_loader
    import eth_cfg_pkg::*;
#(
    parameter int GAP        = 0,
    parameter bit AUTO_START = 1'b1
) (
    input  logic         cfg_clk,
    input  logic         cfg_rst_n,
    input  logic         start,
    input  logic [47:0]  mac,
    input  logic [31:0]  ip,
    input  logic [127:0] udp_ports,
    output logic         cfg_valid,
    output logic         cfg_mem_sel,
    output logic [7:0]   cfg_wdata,
    output logic         cfg_enable_rx,
    output logic         busy,
    output logic         done,
    output logic [7:0]   load_count
);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [3:0]     r_idx;
    logic [3:0]     w_idx_nxt;
    logic           r_first;
    logic [79:0]    r_macip;
    logic [127:0]   r_udp;
    logic           r_valid;
    logic           r_sel;
    logic [7:0]     r_wdata;
    logic           r_en_rx;
    logic           r_busy;
    logic           r_done;
    logic [7:0]     r_count;
    logic           w_accept;
    logic           w_pace_en;
    logic           w_fire;
    logic           w_sel_nxt;
    logic [7:0]     w_byte_nxt;

    // r_first marks the first cycle after reset for the auto-start load.
    assign w_accept  = (r_state == ST_IDLE) && (start || (AUTO_START && r_first));
    assign w_pace_en = (w_state_nxt == ST_PRE) || (w_state_nxt == ST_MACIP) ||
                       (w_state_nxt == ST_UDP);

    eth_cfg_pacer #(.GAP(GAP)) u_pacer (
        .i_clk   (cfg_clk),
        .i_rst_n (cfg_rst_n),
        .i_en    (w_pace_en),
        .o_fire  (w_fire)
    );

    // State register.
    always_ff @(posedge cfg_clk or negedge cfg_rst_n) begin
        if (!cfg_rst_n) r_state <= ST_IDLE;
        else            r_state <= w_state_nxt;
    end

    // Next state: a phase ends when its last byte is on the bus this cycle.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_accept) w_state_nxt = ST_PRE;
            ST_PRE:   if (r_valid) w_state_nxt = ST_MACIP;
            ST_MACIP: if (r_valid && (r_idx == 4'(MACIP_MEM_SZ-1))) w_state_nxt = ST_UDP;
            ST_UDP:   if (r_valid && (r_idx == 4'(UDP_MEM_SZ-1))) w_state_nxt = ST_FIN;
            ST_FIN:   w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Next strobe contents, chosen from the phase the next cycle belongs to.
    always_comb begin
        w_idx_nxt  = (w_state_nxt != r_state) ? 4'd0 :
                     (r_valid ? r_idx + 4'd1 : r_idx);
        w_sel_nxt  = r_sel;
        w_byte_nxt = r_wdata;
        unique case (w_state_nxt)
            ST_PRE: begin
                w_sel_nxt  = SEL_UDP;
                w_byte_nxt = w_accept ? udp_ports[15:8] : r_udp[15:8];
            end
            ST_MACIP: begin
                w_sel_nxt  = SEL_MACIP;
                w_byte_nxt = macip_byte(r_macip, w_idx_nxt);
            end
            ST_UDP: begin
                w_sel_nxt  = SEL_UDP;
                w_byte_nxt = udp_byte(r_udp, w_idx_nxt);
            end
            default: ;
        endcase
    end

    // Byte index, first-cycle flag and shadow copies of the configuration.
    always_ff @(posedge cfg_clk or negedge cfg_rst_n) begin
        if (!cfg_rst_n) begin
            r_idx   <= 4'd0;
            r_first <= 1'b1;
            r_macip <= '0;
            r_udp   <= '0;
        end else begin
            r_idx   <= w_idx_nxt;
            r_first <= 1'b0;
            if (w_accept) begin
                r_macip <= {mac, ip};
                r_udp   <= udp_ports;
            end
        end
    end

    // Registered outputs; select and data hold between strobes.
    always_ff @(posedge cfg_clk or negedge cfg_rst_n) begin
        if (!cfg_rst_n) begin
            r_valid <= 1'b0;
            r_sel   <= 1'b0;
            r_wdata <= 8'd0;
            r_en_rx <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_count <= 8'd0;
        end else begin
            r_valid <= w_fire;
            if (w_fire) begin
                r_sel   <= w_sel_nxt;
                r_wdata <= w_byte_nxt;
            end
            r_busy <= (w_state_nxt != ST_IDLE);
            r_done <= (w_state_nxt == ST_FIN);
            if (w_accept)                    r_en_rx <= 1'b0;
            else if (w_state_nxt == ST_FIN)  r_en_rx <= 1'b1;
            if (w_state_nxt == ST_FIN)       r_count <= r_count + 8'd1;
        end
    end

    assign cfg_valid     = r_valid;
    assign cfg_mem_sel   = r_sel;
    assign cfg_wdata     = r_wdata;
    assign cfg_enable_rx = r_en_rx;
    assign busy          = r_busy;
    assign done          = r_done;
    assign load_count    = r_count;

endmodule

// File: tb/tb_eth_cfg_loader.sv
// Bench for eth_cfg_loader: two instances (GAP=0 auto-start, GAP=3 manual),
// a byte-stream reference and a model of the bridge's address pointer.
module tb_eth_cfg_loader;
    import eth_cfg_pkg::*;

    logic         clk = 1'b0;
    int           cyc = 0;
    logic [1:0]   rst_s, start_s, valid_s, sel_s, en_s, busy_s, done_s;
    logic [7:0]   wdata_s [2];
    logic [7:0]   lc_s [2];
    logic [47:0]  mac;
    logic [31:0]  ip;
    logic [127:0] udp;

    int n_chk = 0;
    int n_err = 0;
    int exp_lc [2];

    // Bridge model: select history, write pointer and the two memories.
    int         b_prev, b_ptr;
    logic [7:0] mem_m [MACIP_MEM_SZ];
    logic [7:0] mem_u [UDP_MEM_SZ];
    logic [8:0] exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    eth_cfg_loader #(.GAP(0), .AUTO_START(1'b1)) dut0 (
        .cfg_clk(clk), .cfg_rst_n(rst_s[0]), .start(start_s[0]),
        .mac(mac), .ip(ip), .udp_ports(udp),
        .cfg_valid(valid_s[0]), .cfg_mem_sel(sel_s[0]), .cfg_wdata(wdata_s[0]),
        .cfg_enable_rx(en_s[0]), .busy(busy_s[0]), .done(done_s[0]), .load_count(lc_s[0])
    );

    eth_cfg_loader #(.GAP(3), .AUTO_START(1'b0)) dut3 (
        .cfg_clk(clk), .cfg_rst_n(rst_s[1]), .start(start_s[1]),
        .mac(mac), .ip(ip), .udp_ports(udp),
        .cfg_valid(valid_s[1]), .cfg_mem_sel(sel_s[1]), .cfg_wdata(wdata_s[1]),
        .cfg_enable_rx(en_s[1]), .busy(busy_s[1]), .done(done_s[1]), .load_count(lc_s[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bridge behaviour: a select change resets the pointer to 0.
    task automatic bridge_write(input logic s, input logic [7:0] b);
        if (int'(s) != b_prev) b_ptr = 0;
        if (s) begin
            mem_u[b_ptr % UDP_MEM_SZ] = b;
            b_ptr = (b_ptr + 1) % UDP_MEM_SZ;
        end else begin
            mem_m[b_ptr % MACIP_MEM_SZ] = b;
            b_ptr = (b_ptr + 1) % MACIP_MEM_SZ;
        end
        b_prev = int'(s);
    endtask

    task automatic randomize_inputs();
        mac = 48'({$urandom, $urandom});
        ip  = $urandom;
        udp = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic check_reset_outputs(input int d, input string tag);
        chk({tag, "_valid"}, 32'(valid_s[d]), 32'd0);
        chk({tag, "_sel"},   32'(sel_s[d]),   32'd0);
        chk({tag, "_wdata"}, 32'(wdata_s[d]), 32'd0);
        chk({tag, "_en_rx"}, 32'(en_s[d]),    32'd0);
        chk({tag, "_busy"},  32'(busy_s[d]),  32'd0);
        chk({tag, "_done"},  32'(done_s[d]),  32'd0);
        chk({tag, "_count"}, 32'(lc_s[d]),    32'd0);
    endtask

    // One full load on instance d, checked strobe by strobe.
    task automatic do_load(input int d, input bit drv, input int acc_in, input int psel,
                           input bit pulse5, input bit pulse_fin, input bit scramble);
        int         gap, acc, k;
        bit         fin;
        logic [8:0] e;
        logic [15:0] port;
        logic [7:0] em_m [MACIP_MEM_SZ];
        logic [7:0] em_u [UDP_MEM_SZ];
        gap = (d == 0) ? 0 : 3;
        for (int i = 0; i < 6; i++) em_m[i] = mac[47-8*i -: 8];
        for (int i = 0; i < 4; i++) em_m[6+i] = ip[31-8*i -: 8];
        for (int p = 0; p < 8; p++) begin
            port = udp[16*p +: 16];
            em_u[2*p]   = port[15:8];
            em_u[2*p+1] = port[7:0];
        end
        exp_q.delete();
        exp_q.push_back({1'b1, em_u[0]});
        for (int i = 0; i < MACIP_MEM_SZ; i++) exp_q.push_back({1'b0, em_m[i]});
        for (int i = 0; i < UDP_MEM_SZ; i++)   exp_q.push_back({1'b1, em_u[i]});
        b_prev = (psel < 0) ? int'($urandom_range(0, 1)) : psel;
        b_ptr  = int'($urandom_range(0, 15));
        for (int i = 0; i < MACIP_MEM_SZ; i++) mem_m[i] = 8'($urandom);
        for (int i = 0; i < UDP_MEM_SZ; i++)   mem_u[i] = 8'($urandom);
        if (drv) begin
            @(negedge clk);
            start_s[d] = 1'b1;
            acc = cyc + 1;
        end else begin
            acc = acc_in;
        end
        k = 0;
        fin = 1'b0;
        for (int c = 0; c < 200 && !fin; c++) begin
            @(negedge clk);
            start_s[d] = 1'b0;
            if (valid_s[d]) begin
                chk("strobe_cycle", 32'(cyc), 32'(acc + k*(gap+1)));
                if (exp_q.size() == 0) begin
                    chk("extra_strobe", 32'(k), 32'(LOAD_STROBES));
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_sel_byte", 32'({sel_s[d], wdata_s[d]}), 32'(e));
                end
                bridge_write(sel_s[d], wdata_s[d]);
                k++;
                if (pulse5 && k == 5) start_s[d] = 1'b1;
                if (scramble && k == 1) randomize_inputs();
            end
            if (done_s[d]) begin
                fin = 1'b1;
                exp_lc[d] = (exp_lc[d] + 1) % 256;
                chk("done_cycle", 32'(cyc), 32'(acc + (LOAD_STROBES-1)*(gap+1) + 1));
                chk("strobe_total", 32'(k), 32'(LOAD_STROBES));
                chk("en_rx_at_fin", 32'(en_s[d]), 32'd1);
                chk("busy_at_fin", 32'(busy_s[d]), 32'd1);
                chk("load_count", 32'(lc_s[d]), 32'(exp_lc[d]));
                if (pulse_fin) start_s[d] = 1'b1;
            end else begin
                chk("busy_in_load", 32'(busy_s[d]), 32'd1);
                chk("en_rx_in_load", 32'(en_s[d]), 32'd0);
            end
        end
        if (!fin) chk("done_timeout", 32'd0, 32'd1);
        if (pulse_fin) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                start_s[d] = 1'b0;
                chk("idle_valid", 32'(valid_s[d]), 32'd0);
                chk("idle_busy", 32'(busy_s[d]), 32'd0);
                chk("idle_done", 32'(done_s[d]), 32'd0);
            end
        end
        for (int i = 0; i < MACIP_MEM_SZ; i++) chk("bridge_macip_mem", 32'(mem_m[i]), 32'(em_m[i]));
        for (int i = 0; i < UDP_MEM_SZ; i++)   chk("bridge_udp_mem", 32'(mem_u[i]), 32'(em_u[i]));
    endtask

    initial begin
        int acc;
        rst_s   = 2'b00;
        start_s = 2'b00;
        mac     = 48'h112233445566;
        ip      = 32'hC0A80704;
        udp     = '0;
        exp_lc[0] = 0;
        exp_lc[1] = 0;

        // Reset state of both instances.
        repeat (3) @(negedge clk);
        check_reset_outputs(0, "reset0");
        check_reset_outputs(1, "reset3");

        // Auto-start on release with the reference vector.
        @(negedge clk);
        rst_s = 2'b11;
        acc = cyc + 1;
        do_load(0, 1'b0, acc, -1, 1'b0, 1'b0, 1'b0);
        chk("no_autostart_busy", 32'(busy_s[1]), 32'd0);
        chk("no_autostart_count", 32'(lc_s[1]), 32'd0);

        // Both bridge select presets, random data changed mid-load.
        for (int p = 0; p < 2; p++) begin
            randomize_inputs();
            do_load(0, 1'b1, 0, p, 1'b0, 1'b0, 1'b1);
        end

        // GAP=3 pacing with port0 = 0x0BB8.
        randomize_inputs();
        udp[15:0] = 16'h0BB8;
        do_load(1, 1'b1, 0, -1, 1'b0, 1'b0, 1'b0);

        // start during the load and on the FIN cycle must be ignored.
        randomize_inputs();
        do_load(0, 1'b1, 0, -1, 1'b1, 1'b1, 1'b0);

        // Reset asserted during the UDP phase of a GAP=3 load.
        randomize_inputs();
        @(negedge clk);
        start_s[1] = 1'b1;
        @(negedge clk);
        start_s[1] = 1'b0;
        repeat (48) @(negedge clk);
        chk("udp_phase_sel", 32'(sel_s[1]), 32'd1);
        chk("udp_phase_busy", 32'(busy_s[1]), 32'd1);
        #2 rst_s[1] = 1'b0;
        #1 check_reset_outputs(1, "async_reset");
        @(negedge clk);
        rst_s[1] = 1'b1;
        exp_lc[1] = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("post_reset_en_rx", 32'(en_s[1]), 32'd0);
            chk("post_reset_valid", 32'(valid_s[1]), 32'd0);
        end
        randomize_inputs();
        do_load(1, 1'b1, 0, -1, 1'b0, 1'b0, 1'b0);

        // 256 back-to-back loads: load_count wraps through zero.
        for (int n = 0; n < 256; n++) begin
            randomize_inputs();
            do_load(0, 1'b1, 0, -1, 1'b0, 1'b0, 1'b0);
            if (exp_lc[0] == 0) chk("count_wrapped_zero", 32'(lc_s[0]), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
